// File: rtl/pipelined_addsub_pkg.sv
// Shared helpers for the segmented add/subtract pipeline.
//   lat()    : advancing edges from operand sample to result (NSEG + 1)
//   cfg_ok() : legal WIDTH/SEG combination
//   seg_lo() : LSB position of the segment added by a given stage
package pipelined_addsub_pkg;

    function automatic int lat(input int width, input int seg);
        return width / seg + 1;
    endfunction

    function automatic bit cfg_ok(input int width, input int seg);
        return (seg >= 1) && (width >= seg) && ((width % seg) == 0);
    endfunction

    // Stage 1 adds segment 0, stage k adds segment k-1.
    function automatic int seg_lo(input int idx, input int seg);
        return (idx - 1) * seg;
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result bundle of pipelined_addsub.
//   en        : pipeline advance (0 = every register holds)
//   valid_in  : operand qualifier
//   a, b      : operands
//   ci        : carry-in (add) / borrow-in (sub)
//   sub       : per-operation mode, 0 = add, 1 = subtract
//   valid_out : result qualifier
//   s         : sum/difference, modulo 2^WIDTH
//   co        : raw carry out of the MSB (sub: 1 = no borrow)
//   ov        : two's-complement signed overflow
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             valid_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             valid_out;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;

    modport master (
        output en, valid_in, a, b, ci, sub,
        input  valid_out, s, co, ov
    );

    modport slave (
        input  en, valid_in, a, b, ci, sub,
        output valid_out, s, co, ov
    );
endinterface

// File: rtl/pipelined_addsub_seg_stage.sv
// One segment of the carry pipeline: adds segment IDX-1 of the operands
// with the carry from the previous stage and registers everything the
// following stage needs.
//   clk, rst     : clock, async active-high reset
//   en_i         : advance; 0 holds all registers
//   valid_i/_o   : slot qualifier
//   c_i/c_o      : carry into / out of this segment
//   a_i/b_i      : operands (b already inverted for sub), forwarded as-is
//   s_i/s_o      : result so far; this stage fills in its own segment
//   ov_o         : signed overflow taken at this segment's MSB (only the
//                  last stage's value is architecturally meaningful)
module pipelined_addsub_seg_stage
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8,
    parameter int IDX   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic             c_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] s_i,
    output logic             valid_o,
    output logic             c_o,
    output logic             ov_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] s_o
);
    localparam int LO  = seg_lo(IDX, SEG);
    localparam int MSB = LO + SEG - 1;

    logic [SEG:0]     seg_sum;
    logic [WIDTH-1:0] s_d;
    logic             ov_d;

    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             c_q, v_q, ov_q;

    assign seg_sum = {1'b0, a_i[LO +: SEG]} + {1'b0, b_i[LO +: SEG]} + {{SEG{1'b0}}, c_i};

    always_comb begin
        s_d           = s_i;
        s_d[LO +: SEG] = seg_sum[SEG-1:0];
    end

    // Same-sign operands producing a differently-signed result; equivalent
    // to carry-into-MSB XOR carry-out-of-MSB without splitting the adder.
    assign ov_d = ~(a_i[MSB] ^ b_i[MSB]) & (a_i[MSB] ^ seg_sum[SEG-1]);

    // Lower operand bits are dead after their segment is added; they are
    // forwarded anyway and pruned by synthesis since nothing reads them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            s_q  <= '0;
            c_q  <= 1'b0;
            v_q  <= 1'b0;
            ov_q <= 1'b0;
        end else if (en_i) begin
            a_q  <= a_i;
            b_q  <= b_i;
            s_q  <= s_d;
            c_q  <= seg_sum[SEG];
            v_q  <= valid_i;
            ov_q <= ov_d;
        end
    end

    assign a_o     = a_q;
    assign b_o     = b_q;
    assign s_o     = s_q;
    assign c_o     = c_q;
    assign valid_o = v_q;
    assign ov_o    = ov_q;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit. The carry ripples one SEG-bit segment per
// stage, so timing is independent of WIDTH. One result per advancing cycle,
// latency NSEG+1 advancing edges, all outputs straight from registers.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of pipelined_addsub_if (operands in, result out)
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic               clk,
    input  logic               rst,
    pipelined_addsub_if.slave  bus
);
    localparam int NSEG = WIDTH / SEG;

    if (!cfg_ok(WIDTH, SEG)) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be a positive multiple of SEG");
    end

    logic [WIDTH-1:0] a_d, a_q, b_d, b_q;
    logic             c_d, c_q, v_q;

    logic [WIDTH-1:0] a_w [NSEG+1];
    logic [WIDTH-1:0] b_w [NSEG+1];
    logic [WIDTH-1:0] s_w [NSEG+1];
    logic             c_w [NSEG+1];
    logic             v_w [NSEG+1];
    logic             ov_w [1:NSEG];

    // a - b - ci == a + ~b + ~ci, so the mode is folded in at the input
    // register and each slot carries its own mode implicitly.
    always_comb begin
        a_d = bus.a;
        b_d = bus.sub ? ~bus.b : bus.b;
        c_d = bus.sub ? ~bus.ci : bus.ci;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= 1'b0;
            v_q <= 1'b0;
        end else if (bus.en) begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            v_q <= bus.valid_in;
        end
    end

    assign a_w[0] = a_q;
    assign b_w[0] = b_q;
    assign s_w[0] = '0;
    assign c_w[0] = c_q;
    assign v_w[0] = v_q;

    for (genvar k = 1; k <= NSEG; k++) begin : g_stage
        pipelined_addsub_seg_stage #(
            .WIDTH (WIDTH),
            .SEG   (SEG),
            .IDX   (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (bus.en),
            .valid_i (v_w[k-1]),
            .c_i     (c_w[k-1]),
            .a_i     (a_w[k-1]),
            .b_i     (b_w[k-1]),
            .s_i     (s_w[k-1]),
            .valid_o (v_w[k]),
            .c_o     (c_w[k]),
            .ov_o    (ov_w[k]),
            .a_o     (a_w[k]),
            .b_o     (b_w[k]),
            .s_o     (s_w[k])
        );
    end

    assign bus.valid_out = v_w[NSEG];
    assign bus.s         = s_w[NSEG];
    assign bus.co        = c_w[NSEG];
    assign bus.ov        = ov_w[NSEG];

endmodule
